alu_acc_seq: RTL and testbench

Sequencing front-end for the 4-bit ALU. It accepts one command at a time over a valid/ready handshake and holds a 4-bit signed accumulator that is always the ALU A operand. It drives the ALU with registered operands, captures the ALU result and flags, and presents them downstream over a second valid/ready handshake. It sits directly upstream of the ALU (feeds op/A/B) and directly downstream of it (consumes result/overflow/zero).

---
 rtl/alu_acc_seq_pkg.sv | 15 +
 rtl/acc_flags_reg.sv | 33 +++
 rtl/alu_acc_seq.sv | 67 ++++++
 tb/tb_alu_acc_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_seq_pkg.sv
// alu_acc_seq_pkg: opcodes, sequencer states and result flag positions shared by the ALU front-end
package alu_acc_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;
  localparam int FLG_ZERO   = 0;
  localparam int FLG_OVF    = 1;
  localparam int FLG_STICKY = 2;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_seq_state_t;
endpackage

// File: rtl/acc_flags_reg.sv
// acc_flags_reg: accumulator, captured result and flag registers loaded at the close of EXEC
module acc_flags_reg
  import alu_acc_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cap,
  input  logic       load,
  input  logic [2:0] op,
  input  logic [3:0] imm,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic [3:0] acc,
  output logic [3:0] res_data,
  output logic [2:0] res_flags
);
  logic cmp;
  assign cmp = op == OP_CMP;
  // loads bypass the ALU; compares report but leave acc and sticky alone
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc       <= '0;
      res_data  <= '0;
      res_flags <= '0;
    end else if (cap) begin
      acc                   <= load ? imm : cmp ? acc : alu_result;
      res_data              <= load ? imm : alu_result;
      res_flags[FLG_ZERO]   <= load ? imm == 4'd0 : alu_zero;
      res_flags[FLG_OVF]    <= !load && !cmp && alu_overflow;
      res_flags[FLG_STICKY] <= !load && (res_flags[FLG_STICKY] || (!cmp && alu_overflow));
    end
endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: valid/ready sequencer that feeds the ALU from an accumulator and returns its results
module alu_acc_seq
  import alu_acc_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_imm,
  input  logic             cmd_load,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [2:0]       res_flags,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_count
);
  alu_seq_state_t state;
  logic load_q;
  assign cmd_ready = state == IDLE;
  assign res_valid = state == RESP;
  assign alu_a     = acc;
  // IDLE -> EXEC on command, one EXEC cycle, RESP until the result is taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      alu_op   <= '0;
      alu_b    <= '0;
      load_q   <= 1'b0;
      op_count <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        state  <= EXEC;
        alu_op <= cmd_op;
        alu_b  <= cmd_imm;
        load_q <= cmd_load;
      end
      if (state == EXEC) state <= RESP;
      if (state == RESP && res_ready) begin
        state    <= IDLE;
        op_count <= op_count + CNT_W'(1);
      end
    end
  acc_flags_reg u_regs (
    .clk          (clk),
    .rst          (rst),
    .cap          (state == EXEC),
    .load         (load_q),
    .op           (alu_op),
    .imm          (alu_b),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .acc          (acc),
    .res_data     (res_data),
    .res_flags    (res_flags)
  );
endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: directed checks of the ALU sequencer against a behavioural 4-bit ALU
module tb_alu_acc_seq;
  import alu_acc_seq_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_imm = '0;
  logic       cmd_load = 1'b0;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_overflow, alu_zero;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_data;
  logic [2:0] res_flags;
  logic [3:0] acc;
  logic [7:0] op_count;
  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  int cyc = 0;
  logic [3:0] sum, dif;
  logic add_ovf, sub_ovf;

  alu_acc_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_load(cmd_load),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .acc(acc), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    sum = alu_a + alu_b;
    dif = alu_a - alu_b;
    add_ovf = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
    sub_ovf = (alu_a[3] != alu_b[3]) && (dif[3] != alu_a[3]);
    alu_result = 4'd0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin alu_result = add_ovf ? 4'd0 : sum; alu_overflow = add_ovf; end
      OP_SUB: begin alu_result = sub_ovf ? 4'd0 : dif; alu_overflow = sub_ovf; end
      OP_NOT: alu_result = ~alu_a;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_CMP: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 4'd1 : 4'd0;
      default: alu_result = 4'd0;
    endcase
    alu_zero = alu_result == 4'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] imm, input logic ld);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm; cmd_load = ld;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int k;
    k = 0;
    while (!res_valid && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_valid"}, res_valid, 1);
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [3:0] imm, input logic ld,
                      input logic [3:0] d, input logic [2:0] f, input logic [3:0] a);
    cmd(op, imm, ld);
    wait_res(tag);
    chk({tag, "_data"}, res_data, d);
    chk({tag, "_flags"}, res_flags, f);
    chk({tag, "_acc"}, acc, a);
    @(negedge clk);
    exp_cnt++;
    chk({tag, "_cnt"}, op_count, exp_cnt);
  endtask

  initial begin
    int bad, prev, k;
    logic timed_out;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_op_count", op_count, 0);
    rst = 1'b0;

    step("ld5",   OP_ADD, 4'd5, 1'b1, 4'd5, 3'b000, 4'd5);
    step("add2",  OP_ADD, 4'd2, 1'b0, 4'd7, 3'b000, 4'd7);
    step("ld7",   OP_ADD, 4'd7, 1'b1, 4'd7, 3'b000, 4'd7);
    step("add1",  OP_ADD, 4'd1, 1'b0, 4'd0, 3'b111, 4'd0);
    step("sub1",  OP_SUB, 4'd1, 1'b0, 4'hF, 3'b100, 4'hF);
    step("ld0",   OP_ADD, 4'd0, 1'b1, 4'd0, 3'b001, 4'd0);
    step("ldE",   OP_ADD, 4'hE, 1'b1, 4'hE, 3'b000, 4'hE);
    step("cmp1",  OP_CMP, 4'd1, 1'b0, 4'd1, 3'b000, 4'hE);
    step("cmpeq", OP_CMP, 4'hE, 1'b0, 4'd0, 3'b001, 4'hE);
    step("and6",  OP_AND, 4'd6, 1'b0, 4'd6, 3'b000, 4'd6);
    step("or9",   OP_OR,  4'd9, 1'b0, 4'hF, 3'b000, 4'hF);
    step("xorF",  OP_XOR, 4'hF, 1'b0, 4'd0, 3'b001, 4'd0);
    step("ld3",   OP_ADD, 4'd3, 1'b1, 4'd3, 3'b000, 4'd3);
    step("rsv",   OP_RSV, 4'd5, 1'b0, 4'd0, 3'b001, 4'd0);

    res_ready = 1'b0;
    cmd(OP_ADD, 4'd3, 1'b1);
    wait_res("bp");
    chk("bp_data0", res_data, 3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 3);
      chk("bp_flags", res_flags, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_cnt", op_count, exp_cnt);
    end
    res_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_release_cnt", op_count, exp_cnt);
    chk("bp_release_valid", res_valid, 0);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_imm = 4'd9; cmd_load = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("mid_exec_alu_b", alu_b, 9);
    chk("mid_exec_valid", res_valid, 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_flags", res_flags, 0);
    chk("mid_rst_cnt", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_acc", acc, 0);

    cmd_op = OP_NOT; cmd_imm = 4'd0; cmd_load = 1'b0; res_ready = 1'b1;
    cmd_valid = 1'b1;
    bad = 0; prev = 0; timed_out = 1'b0;
    for (int i = 0; i < 256; i++) begin
      k = 0;
      while (!res_valid && k < 10) begin @(negedge clk); k++; end
      if (!res_valid) begin
        timed_out = 1'b1;
        break;
      end
      if (i > 0 && cyc - prev != 3) bad++;
      prev = cyc;
      if (i == 255) begin
        chk("thru_cnt255", op_count, 255);
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("thru_timeout", timed_out, 0);
    chk("thru_interval", bad, 0);
    chk("thru_wrap_cnt", op_count, 0);
    chk("thru_acc", acc, 0);
    chk("thru_flags", res_flags, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
